store_bin: RTL and testbench
============================

# store_bin

Write-back stage for the bin manager and the counterpart of the bin loader. When the SAT engine finishes a bin, this block collects the engine's per-slot variable states and local level states and writes them back into the global var-state RAM and lvl-state RAM. After `done_update` the next bin can be loaded.

## Interface
Parameters:
- `NUM_VARS_A_BIN`, 8: variable slots per bin.
- `NUM_LVLS_A_BIN`, 8: level slots per bin.
- `WIDTH_VAR`, 12: width of a global variable id.
- `WIDTH_LVL`, 16: width of a decision level.
- `WIDTH_BIN_ID`, 10: width of a bin number.
- `WIDTH_VAR_STATES`, 19: width of one var-state word.
- `WIDTH_LVL_STATES`, 11: width of one lvl-state word.
- `ADDR_WIDTH_VAR`, 9: vars-bin RAM address width.
- `ADDR_WIDTH_VAR_STATES`, 9: var-state RAM address width.
- `ADDR_WIDTH_LVL_STATES`, 9: lvl-state RAM address width.

Ports:
- `clk`  in  1  the single clock.
- `rst`  in  1  synchronous, active-high reset.
- `start_update`  in  1  one-cycle request; accepted only in IDLE.
- `bin_num_i`  in  WIDTH_BIN_ID  bin being written back (1-based).
- `base_lvl_i`  in  WIDTH_LVL  base level the bin was loaded with.
- `cur_lvl_i`  in  WIDTH_LVL  engine's current level at finish.
- `apply_update_o`  out  1  high while VARS or LVLS is active; drives the BRAM port mux.
- `done_update`  out  1  one-cycle completion pulse.
- `var_states_i`  in  WIDTH_VAR_STATES*NUM_VARS_A_BIN  engine var states, slot 0 in the LSBs.
- `lvl_states_i`  in  WIDTH_LVL_STATES*NUM_LVLS_A_BIN  engine lvl states, slot 0 in the LSBs.
- `ram_addr_v_o`  out  ADDR_WIDTH_VAR  vars-bin RAM read address.
- `ram_data_v_i`  in  WIDTH_VAR  vars-bin RAM read data; one-cycle read latency.
- `ram_we_vs_o`, `ram_addr_vs_o`, `ram_data_vs_o`  out  1 / ADDR_WIDTH_VAR_STATES / WIDTH_VAR_STATES  var-state RAM write port.
- `ram_we_ls_o`, `ram_addr_ls_o`, `ram_data_ls_o`  out  1 / ADDR_WIDTH_LVL_STATES / WIDTH_LVL_STATES  lvl-state RAM write port.

## Operation
- FSM states: IDLE, VARS, LVLS, DONE.
- IDLE → VARS on `start_update`. In the same edge, latch:
  - `vbase = (bin_num_i-1)*NUM_VARS_A_BIN+1`, truncated to ADDR_WIDTH_VAR.
  - `base_lvl_i`.
  - `n_lvl = min(cur_lvl_i - base_lvl_i, NUM_LVLS_A_BIN)`, or 0 if `cur_lvl_i <= base_lvl_i`. Compute in WIDTH_LVL bits; no wrap.
- VARS uses counter k = 0..NUM_VARS_A_BIN, i.e. NUM_VARS_A_BIN+1 cycles.
  - For k < N: `ram_addr_v_o = vbase + k`.
  - For k ≥ 1: write slot k-1. Set `ram_we_vs_o = 1`, `ram_addr_vs_o = ram_data_v_i` (low ADDR_WIDTH_VAR_STATES bits), `ram_data_vs_o` = slice k-1 of `var_states_i`.
  - A var id of 0 marks an empty slot: `ram_we_vs_o` stays 0 for that slot.
- VARS → LVLS after the k = N cycle, or VARS → DONE directly if `n_lvl == 0`.
- LVLS uses counter j = 0..n_lvl-1.
  - Each cycle: `ram_we_ls_o = 1`, `ram_addr_ls_o = base_lvl + 1 + j`, `ram_data_ls_o` = slice j of `lvl_states_i`.
  - LVLS → DONE after j = n_lvl-1.
- DONE: `done_update = 1` for one cycle, then → IDLE.
- `start_update` outside IDLE is ignored. `var_states_i` and `lvl_states_i` must be held stable from `start_update` until `done_update`.

## Timing
- Reset values: all outputs 0; FSM in IDLE; counters 0.
- Cycle numbering: `start_update` is sampled in cycle 0.
  - VARS occupies cycles 1..N+1.
  - LVLS occupies cycles N+2..N+1+n_lvl.
  - `done_update` is high in cycle N+2+n_lvl; with defaults and n_lvl = 8, that is cycle 18.
- Write enables are driven from registered state and counters. Write data is slice-selected from the inputs in the same cycle.
- `apply_update_o` is high in exactly the VARS and LVLS cycles.
- Reset asserted mid-operation: on the next edge the FSM returns to IDLE and all write enables drop to 0. A partial write-back is not resumed.
- `start_update` asserted in the DONE cycle is ignored.

## Structure
- Shared package (`bin_defs`): FSM state encodings, the empty-var-id constant (0), and default widths.
- One sub-module, `gather_from_8_datas`: parameterised by WIDTH, it selects slice `sel` from a packed 8-word vector. It is the inverse of the scatter helper. Instantiate it twice, once for var states and once for lvl states.

## Test plan
- Full bin, defaults: bin 2, base_lvl 3, cur_lvl 5, vars-bin RAM holds ids 10..17 at addresses 9..16 → 8 var-state writes to addresses 10..17 in cycles 2..9; ls writes to addresses 4 and 5 in cycles 10–11; `done_update` in cycle 12.
- Empty slots: ids at slots 3 and 6 = 0 → exactly 6 `ram_we_vs_o` pulses; none in cycles 5 and 8.
- No local levels: cur_lvl = base_lvl = 7 → no `ram_we_ls_o`; `done_update` in cycle 10.
- Clamp and underflow: cur_lvl − base_lvl = 20 → exactly 8 ls writes, to base+1..base+8. cur_lvl < base_lvl → 0 ls writes.
- Reset mid-VARS in cycle 4 → all outputs 0 from cycle 5; a later `start_update` runs a full, correct sequence.
- `start_update` re-pulsed during LVLS and during DONE → ignored; exactly one `done_update`.

Source files
------------

// File: rtl/bin_defs.sv
// Shared definitions for the bin loader / write-back pair:
// FSM encoding, the empty-slot marker and default widths.
package bin_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_VARS = 2'd1,
        ST_LVLS = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int EMPTY_VAR_ID = 0;

    localparam int DEF_NUM_VARS_A_BIN        = 8;
    localparam int DEF_NUM_LVLS_A_BIN        = 8;
    localparam int DEF_WIDTH_VAR             = 12;
    localparam int DEF_WIDTH_LVL             = 16;
    localparam int DEF_WIDTH_BIN_ID          = 10;
    localparam int DEF_WIDTH_VAR_STATES      = 19;
    localparam int DEF_WIDTH_LVL_STATES      = 11;
    localparam int DEF_ADDR_WIDTH_VAR        = 9;
    localparam int DEF_ADDR_WIDTH_VAR_STATES = 9;
    localparam int DEF_ADDR_WIDTH_LVL_STATES = 9;

endpackage

// File: rtl/gather_from_8_datas.sv
// Selects word i_sel out of a packed 8-word vector (word 0 in the LSBs);
// inverse of the scatter helper used by the bin loader.
module gather_from_8_datas #(
    parameter int WIDTH = 8
) (
    input  logic [8*WIDTH-1:0] i_datas,
    input  logic [2:0]         i_sel,
    output logic [WIDTH-1:0]   o_data
);

    assign o_data = i_datas[i_sel*WIDTH +: WIDTH];

endmodule

// File: rtl/store_bin.sv
// Write-back of a finished bin: per-slot var states go to the var-state RAM
// (addressed by the var ids read from the vars-bin RAM), then local lvl states.
module store_bin
    import bin_defs::*;
#(
    parameter int NUM_VARS_A_BIN        = DEF_NUM_VARS_A_BIN,
    parameter int NUM_LVLS_A_BIN        = DEF_NUM_LVLS_A_BIN,
    parameter int WIDTH_VAR             = DEF_WIDTH_VAR,
    parameter int WIDTH_LVL             = DEF_WIDTH_LVL,
    parameter int WIDTH_BIN_ID          = DEF_WIDTH_BIN_ID,
    parameter int WIDTH_VAR_STATES      = DEF_WIDTH_VAR_STATES,
    parameter int WIDTH_LVL_STATES      = DEF_WIDTH_LVL_STATES,
    parameter int ADDR_WIDTH_VAR        = DEF_ADDR_WIDTH_VAR,
    parameter int ADDR_WIDTH_VAR_STATES = DEF_ADDR_WIDTH_VAR_STATES,
    parameter int ADDR_WIDTH_LVL_STATES = DEF_ADDR_WIDTH_LVL_STATES
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start_update,
    input  logic [WIDTH_BIN_ID-1:0]                     bin_num_i,
    input  logic [WIDTH_LVL-1:0]                        base_lvl_i,
    input  logic [WIDTH_LVL-1:0]                        cur_lvl_i,
    output logic                                        apply_update_o,
    output logic                                        done_update,
    input  logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0]  var_states_i,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS_A_BIN-1:0]  lvl_states_i,
    output logic [ADDR_WIDTH_VAR-1:0]                   ram_addr_v_o,
    input  logic [WIDTH_VAR-1:0]                        ram_data_v_i,
    output logic                                        ram_we_vs_o,
    output logic [ADDR_WIDTH_VAR_STATES-1:0]            ram_addr_vs_o,
    output logic [WIDTH_VAR_STATES-1:0]                 ram_data_vs_o,
    output logic                                        ram_we_ls_o,
    output logic [ADDR_WIDTH_LVL_STATES-1:0]            ram_addr_ls_o,
    output logic [WIDTH_LVL_STATES-1:0]                 ram_data_ls_o
);

    localparam int CW_V = $clog2(NUM_VARS_A_BIN + 1);
    localparam int CW_L = $clog2(NUM_LVLS_A_BIN + 1);

    state_t                     r_state;
    logic [CW_V-1:0]            r_k;
    logic [CW_L-1:0]            r_j;
    logic [CW_L-1:0]            r_nlvl;
    logic [ADDR_WIDTH_VAR-1:0]  r_vbase;
    logic [WIDTH_LVL-1:0]       r_base_lvl;

    logic [WIDTH_LVL-1:0]        w_diff;
    logic [CW_L-1:0]             w_nlvl;
    logic [2:0]                  w_vsel;
    logic [2:0]                  w_lsel;
    logic [WIDTH_VAR_STATES-1:0] w_vs_word;
    logic [WIDTH_LVL_STATES-1:0] w_ls_word;
    logic                        w_in_vars;
    logic                        w_in_lvls;
    logic                        w_we_vs;

    // Level count is clamped to the bin size; a non-positive span means none.
    assign w_diff = cur_lvl_i - base_lvl_i;
    assign w_nlvl = (cur_lvl_i <= base_lvl_i) ? '0 :
                    (w_diff > WIDTH_LVL'(NUM_LVLS_A_BIN)) ? CW_L'(NUM_LVLS_A_BIN) :
                    CW_L'(w_diff);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_k        <= '0;
            r_j        <= '0;
            r_nlvl     <= '0;
            r_vbase    <= '0;
            r_base_lvl <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_update) begin
                        r_vbase    <= ADDR_WIDTH_VAR'((32'(bin_num_i) - 32'd1)
                                      * 32'(NUM_VARS_A_BIN) + 32'd1);
                        r_base_lvl <= base_lvl_i;
                        r_nlvl     <= w_nlvl;
                        r_k        <= '0;
                        r_j        <= '0;
                        r_state    <= ST_VARS;
                    end
                end
                ST_VARS: begin
                    if (r_k == CW_V'(NUM_VARS_A_BIN)) begin
                        r_k     <= '0;
                        r_j     <= '0;
                        r_state <= (r_nlvl == '0) ? ST_DONE : ST_LVLS;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                ST_LVLS: begin
                    if (r_j == CW_L'(r_nlvl - 1'b1)) begin
                        r_j     <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_in_vars = (r_state == ST_VARS);
    assign w_in_lvls = (r_state == ST_LVLS);

    // RAM data in cycle k answers the address issued in cycle k-1, i.e. slot k-1.
    assign w_vsel  = 3'(r_k - 1'b1);
    assign w_lsel  = 3'(r_j);
    assign w_we_vs = w_in_vars && (r_k != '0)
                     && (ram_data_v_i != WIDTH_VAR'(EMPTY_VAR_ID));

    gather_from_8_datas #(.WIDTH(WIDTH_VAR_STATES)) u_gather_vs (
        .i_datas (var_states_i),
        .i_sel   (w_vsel),
        .o_data  (w_vs_word)
    );

    gather_from_8_datas #(.WIDTH(WIDTH_LVL_STATES)) u_gather_ls (
        .i_datas (lvl_states_i),
        .i_sel   (w_lsel),
        .o_data  (w_ls_word)
    );

    assign apply_update_o = w_in_vars || w_in_lvls;
    assign done_update    = (r_state == ST_DONE);

    assign ram_addr_v_o  = (w_in_vars && (r_k < CW_V'(NUM_VARS_A_BIN)))
                           ? r_vbase + ADDR_WIDTH_VAR'(r_k) : '0;

    assign ram_we_vs_o   = w_we_vs;
    assign ram_addr_vs_o = w_we_vs ? ADDR_WIDTH_VAR_STATES'(ram_data_v_i) : '0;
    assign ram_data_vs_o = w_we_vs ? w_vs_word : '0;

    assign ram_we_ls_o   = w_in_lvls;
    assign ram_addr_ls_o = w_in_lvls
                           ? ADDR_WIDTH_LVL_STATES'(r_base_lvl + WIDTH_LVL'(r_j) + WIDTH_LVL'(1))
                           : '0;
    assign ram_data_ls_o = w_in_lvls ? w_ls_word : '0;

endmodule

// File: tb/tb_store_bin.sv
// Bench for store_bin: a vars-bin RAM model feeds the DUT, and every cycle of
// each write-back is compared with outputs derived from the write-back rules.
module tb_store_bin;

    localparam int NV  = 8;
    localparam int NL  = 8;
    localparam int WV  = 12;
    localparam int WL  = 16;
    localparam int WB  = 10;
    localparam int WVS = 19;
    localparam int WLS = 11;
    localparam int AV  = 9;
    localparam int AVS = 9;
    localparam int ALS = 9;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start_update = 1'b0;
    logic [WB-1:0]      bin_num_i = '0;
    logic [WL-1:0]      base_lvl_i = '0;
    logic [WL-1:0]      cur_lvl_i = '0;
    logic               apply_update_o;
    logic               done_update;
    logic [WVS*NV-1:0]  var_states_i = '0;
    logic [WLS*NL-1:0]  lvl_states_i = '0;
    logic [AV-1:0]      ram_addr_v_o;
    logic [WV-1:0]      ram_data_v_i = '0;
    logic               ram_we_vs_o;
    logic [AVS-1:0]     ram_addr_vs_o;
    logic [WVS-1:0]     ram_data_vs_o;
    logic               ram_we_ls_o;
    logic [ALS-1:0]     ram_addr_ls_o;
    logic [WLS-1:0]     ram_data_ls_o;

    logic [WV-1:0] mem [0:511];

    int checks = 0;
    int errors = 0;

    int g_bin, g_base, g_cur, g_rst_cycle;

    store_bin #(
        .NUM_VARS_A_BIN(NV), .NUM_LVLS_A_BIN(NL), .WIDTH_VAR(WV), .WIDTH_LVL(WL),
        .WIDTH_BIN_ID(WB), .WIDTH_VAR_STATES(WVS), .WIDTH_LVL_STATES(WLS),
        .ADDR_WIDTH_VAR(AV), .ADDR_WIDTH_VAR_STATES(AVS), .ADDR_WIDTH_LVL_STATES(ALS)
    ) dut (
        .clk(clk), .rst(rst), .start_update(start_update),
        .bin_num_i(bin_num_i), .base_lvl_i(base_lvl_i), .cur_lvl_i(cur_lvl_i),
        .apply_update_o(apply_update_o), .done_update(done_update),
        .var_states_i(var_states_i), .lvl_states_i(lvl_states_i),
        .ram_addr_v_o(ram_addr_v_o), .ram_data_v_i(ram_data_v_i),
        .ram_we_vs_o(ram_we_vs_o), .ram_addr_vs_o(ram_addr_vs_o), .ram_data_vs_o(ram_data_vs_o),
        .ram_we_ls_o(ram_we_ls_o), .ram_addr_ls_o(ram_addr_ls_o), .ram_data_ls_o(ram_data_ls_o)
    );

    always #5 clk = ~clk;

    // Synchronous-read vars-bin RAM, one cycle of latency.
    always @(posedge clk) ram_data_v_i <= mem[ram_addr_v_o];

    logic [60:0] w_obs;
    assign w_obs = {apply_update_o, done_update, ram_addr_v_o,
                    ram_we_vs_o, ram_addr_vs_o, ram_data_vs_o,
                    ram_we_ls_o, ram_addr_ls_o, ram_data_ls_o};

    function automatic int nlvl_of(input int base, input int cur);
        if (cur <= base) return 0;
        return (cur - base > NL) ? NL : cur - base;
    endfunction

    function automatic int vbase_of(input int bin);
        return ((bin - 1) * NV + 1) & 'h1FF;
    endfunction

    // Expected outputs in cycle c, where cycle 0 is the one sampling start_update.
    function automatic logic [60:0] model(input int c);
        int vb, nl, s, j;
        logic [WV-1:0]  id;
        logic           apply, done, we_vs, we_ls;
        logic [AV-1:0]  addr_v;
        logic [AVS-1:0] addr_vs;
        logic [WVS-1:0] data_vs;
        logic [ALS-1:0] addr_ls;
        logic [WLS-1:0] data_ls;
        vb = vbase_of(g_bin);
        nl = nlvl_of(g_base, g_cur);
        apply = 0; done = 0; we_vs = 0; we_ls = 0;
        addr_v = '0; addr_vs = '0; data_vs = '0; addr_ls = '0; data_ls = '0;
        if (c >= 1 && c <= NV + 1) begin
            apply = 1;
            if (c - 1 < NV) addr_v = AV'((vb + c - 1) & 'h1FF);
            if (c >= 2) begin
                s  = c - 2;
                id = mem[(vb + s) & 'h1FF];
                if (id != 0) begin
                    we_vs   = 1;
                    addr_vs = id[AVS-1:0];
                    data_vs = var_states_i[s*WVS +: WVS];
                end
            end
        end else if (c >= NV + 2 && c <= NV + 1 + nl) begin
            j       = c - NV - 2;
            apply   = 1;
            we_ls   = 1;
            addr_ls = ALS'((g_base + 1 + j) & 'h1FF);
            data_ls = lvl_states_i[j*WLS +: WLS];
        end else if (c == NV + 2 + nl) begin
            done = 1;
        end
        if (g_rst_cycle > 0 && c > g_rst_cycle) return '0;
        return {apply, done, addr_v, we_vs, addr_vs, data_vs, we_ls, addr_ls, data_ls};
    endfunction

    task automatic check_vec(input string tag, input int c, input logic [60:0] exp);
        checks++;
        assert (w_obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d got %h expected %h", tag, c, w_obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input int bin, input int base, input int cur,
                          input int rst_c, input int rp1, input int rp2);
        int nl, last, n_done, n_vs, n_ls, exp_vs, exp_ls, exp_done, vb;
        g_bin = bin; g_base = base; g_cur = cur; g_rst_cycle = rst_c;
        nl = nlvl_of(base, cur);
        vb = vbase_of(bin);
        for (int i = 0; i < NV; i++) var_states_i[i*WVS +: WVS] = WVS'($urandom);
        for (int i = 0; i < NL; i++) lvl_states_i[i*WLS +: WLS] = WLS'($urandom);
        exp_vs = 0;
        for (int i = 0; i < NV; i++) if (mem[(vb + i) & 'h1FF] != 0) exp_vs++;
        exp_ls   = nl;
        exp_done = 1;
        if (rst_c > 0) begin
            exp_vs = 0; exp_ls = 0; exp_done = 0;
        end
        n_done = 0; n_vs = 0; n_ls = 0;
        @(posedge clk); #1;
        bin_num_i    = WB'(bin);
        base_lvl_i   = WL'(base);
        cur_lvl_i    = WL'(cur);
        start_update = 1'b1;
        @(negedge clk);
        check_vec(tag, 0, model(0));
        last = NV + 2 + nl + 2;
        for (int c = 1; c <= last; c++) begin
            @(posedge clk); #1;
            start_update = (c == rp1) || (c == rp2);
            rst          = (c == rst_c);
            @(negedge clk);
            check_vec(tag, c, model(c));
            if (done_update) n_done++;
            if (ram_we_vs_o && (rst_c == 0)) n_vs++;
            if (ram_we_ls_o && (rst_c == 0)) n_ls++;
        end
        @(posedge clk); #1;
        start_update = 1'b0;
        rst          = 1'b0;
        checks++;
        assert (n_done == exp_done) else begin
            errors++;
            $error("FAIL %s done_count got %0d expected %0d", tag, n_done, exp_done);
        end
        checks++;
        assert (n_vs == exp_vs) else begin
            errors++;
            $error("FAIL %s vs_write_count got %0d expected %0d", tag, n_vs, exp_vs);
        end
        checks++;
        assert (n_ls == exp_ls) else begin
            errors++;
            $error("FAIL %s ls_write_count got %0d expected %0d", tag, n_ls, exp_ls);
        end
    endtask

    initial begin
        for (int a = 0; a < 512; a++)
            mem[a] = ($urandom_range(0, 3) == 0) ? '0 : WV'($urandom);

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        g_rst_cycle = 0;
        checks++;
        assert (w_obs === '0) else begin
            errors++;
            $error("FAIL reset_outputs got %h expected %h", w_obs, 61'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // full bin: ids 10..17 at 9..16, levels 4 and 5, done in cycle 12
        for (int i = 0; i < NV; i++) mem[9 + i] = WV'(10 + i);
        run_op("full_bin", 2, 3, 5, 0, 0, 0);

        // empty slots 3 and 6
        mem[9 + 3] = '0;
        mem[9 + 6] = '0;
        run_op("empty_slots", 2, 3, 5, 0, 0, 0);

        // no local levels
        run_op("no_lvls", 2, 7, 7, 0, 0, 0);

        // clamp and underflow
        run_op("clamp", 5, 100, 120, 0, 0, 0);
        run_op("underflow", 5, 100, 40, 0, 0, 0);

        // wrapping addresses at the top of both RAMs
        run_op("addr_wrap", 70, 505, 513, 0, 0, 0);

        // reset mid-VARS, then a clean run
        for (int i = 0; i < NV; i++) mem[9 + i] = WV'(10 + i);
        run_op("reset_mid", 2, 3, 11, 4, 0, 0);
        run_op("after_reset", 2, 3, 11, 0, 0, 0);

        // re-pulsed start in LVLS (cycle 11) and DONE (cycle 15) with n_lvl = 5
        run_op("repulse", 2, 10, 15, 0, 11, 15);

        // random write-backs
        for (int t = 0; t < 8; t++) begin
            int b, bl, cl;
            b  = $urandom_range(1, 100);
            bl = $urandom_range(0, 600);
            cl = bl + $urandom_range(0, 14) - 3;
            if (cl < 0) cl = 0;
            run_op("random", b, bl, cl, 0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
